// File: rtl/pixel_capture_pkg.sv
// Shared types and constants for the camera capture write master.
// Used by pixel_capture (optional feature macro: PIXEL_CAPTURE_TESTPAT_EN).
package pixel_capture_pkg;

  typedef enum logic [2:0] {
    C_IDLE,
    C_ARM,
    C_CAPTURE,
    C_DRAIN,
    C_DONE
  } cap_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_WAIT_BUSY,
    W_WAIT_DONE
  } wr_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int unsigned DEFAULT_FRAME_WORDS = 307200;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two (>= 2).
// A push into a full FIFO is accepted only when a pop happens on the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_capture.sv
// Camera-side SRAM write master: syncs the OV-style bus, packs byte pairs into words,
// buffers them and writes one frame per arm. Optional macro: PIXEL_CAPTURE_TESTPAT_EN.
module pixel_capture
  import pixel_capture_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_req,
  input  logic              pixel_clk,
  input  logic              pixel_vsync,
  input  logic              pixel_hsync,
  input  logic [7:0]        pixel_data,
`ifdef PIXEL_CAPTURE_TESTPAT_EN
  input  logic              testpat_sel,
`endif
  input  logic              sram_ready,
  output logic              pixel_start,
  output logic              pixel_rw,
  output logic [ADDR_W-1:0] pixel_sram_addr,
  output logic [15:0]       pixel_sram_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned      WORD_W    = ADDR_W + 16;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  // Camera bus synchronizers and edge detectors.
  logic [1:0] pclk_sync;
  logic [1:0] vsync_sync;
  logic [1:0] hsync_sync;
  logic [7:0] data_meta;
  logic [7:0] data_sync;
  logic       pclk_prev;
  logic       vsync_prev;
  logic       byte_valid;
  logic       vsync_fall;
  logic       vsync_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      hsync_sync <= '0;
      data_meta  <= '0;
      data_sync  <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], pixel_clk};
      vsync_sync <= {vsync_sync[0], pixel_vsync};
      hsync_sync <= {hsync_sync[0], pixel_hsync};
      data_meta  <= pixel_data;
      data_sync  <= data_meta;
      pclk_prev  <= pclk_sync[1];
      vsync_prev <= vsync_sync[1];
    end
  end

  assign byte_valid = pclk_sync[1] && !pclk_prev && hsync_sync[1];
  assign vsync_fall = !vsync_sync[1] && vsync_prev;
  assign vsync_rise = vsync_sync[1] && !vsync_prev;

  cap_state_t        cap_state;
  cap_state_t        cap_next;
  wr_state_t         wr_state;
  wr_state_t         wr_next;
  logic [ADDR_W-1:0] word_cnt;
  logic [7:0]        hi_byte;
  logic              have_hi;
  logic              take_hi;
  logic              clr_pack;
  logic              ovf_clr;
  logic              push;
  logic [7:0]        lo_byte;
  logic [15:0]       word_data;
  logic [WORD_W-1:0] push_word;
  logic              fifo_pop;
  logic [WORD_W-1:0] pop_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;

`ifdef PIXEL_CAPTURE_TESTPAT_EN
  assign word_data = testpat_sel ? 16'(word_cnt) : {hi_byte, lo_byte};
`else
  assign word_data = {hi_byte, lo_byte};
`endif

  assign push_word = {word_cnt, word_data};
  assign fifo_drop = push && fifo_full && !fifo_pop;

  // Capture FSM: vsync end-of-frame wins over a byte arriving on the same cycle.
  always_comb begin
    cap_next = cap_state;
    push     = 1'b0;
    lo_byte  = '0;
    take_hi  = 1'b0;
    clr_pack = 1'b0;
    ovf_clr  = 1'b0;
    case (cap_state)
      C_IDLE, C_DONE: begin
        if (capture_req) begin
          cap_next = C_ARM;
          ovf_clr  = 1'b1;
        end
      end
      C_ARM: begin
        clr_pack = 1'b1;
        if (vsync_fall) begin
          cap_next = C_CAPTURE;
        end
      end
      C_CAPTURE: begin
        if (vsync_rise) begin
          cap_next = C_DRAIN;
          if (have_hi) begin
            push    = 1'b1;
            lo_byte = 8'h00;
          end
        end else if (byte_valid) begin
          if (!have_hi) begin
            take_hi = 1'b1;
          end else begin
            push    = 1'b1;
            lo_byte = data_sync;
            if (word_cnt == LAST_WORD) begin
              cap_next = C_DRAIN;
            end
          end
        end
      end
      C_DRAIN: begin
        if (fifo_empty && wr_state == W_IDLE) begin
          cap_next = C_DONE;
        end
      end
      default: cap_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_state <= C_IDLE;
      word_cnt  <= '0;
      hi_byte   <= '0;
      have_hi   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cap_state <= cap_next;
      if (clr_pack) begin
        word_cnt <= '0;
        hi_byte  <= '0;
        have_hi  <= 1'b0;
      end else if (push) begin
        word_cnt <= word_cnt + 1'b1;
        have_hi  <= 1'b0;
      end else if (take_hi) begin
        hi_byte <= data_sync;
        have_hi <= 1'b1;
      end
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (cap_state inside {C_ARM, C_CAPTURE, C_DRAIN});
  assign done = (cap_state == C_DONE);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    wr_next  = wr_state;
    fifo_pop = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (!fifo_empty && sram_ready) begin
          fifo_pop = 1'b1;
          wr_next  = W_ISSUE;
        end
      end
      W_ISSUE:     wr_next = W_WAIT_BUSY;
      W_WAIT_BUSY: if (!sram_ready) wr_next = W_WAIT_DONE;
      W_WAIT_DONE: if (sram_ready) wr_next = W_IDLE;
      default:     wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state        <= W_IDLE;
      pixel_sram_addr <= '0;
      pixel_sram_data <= '0;
    end else begin
      wr_state <= wr_next;
      if (fifo_pop) begin
        pixel_sram_addr <= pop_word[WORD_W-1:16];
        pixel_sram_data <= pop_word[15:0];
      end
    end
  end

  assign pixel_start = (wr_state != W_ISSUE);
  assign pixel_rw    = RW_WRITE;

endmodule

// File: tb/tb_pixel_capture.sv
// Directed scoreboard bench for pixel_capture: a FRAME_WORDS=4 instance and a
// FRAME_WORDS=12 instance share the camera bus, each with its own SRAM responder.
module tb_pixel_capture;

  localparam int unsigned AW = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_s, req_b;
  logic        pixel_clk, pixel_vsync, pixel_hsync;
  logic [7:0]  pixel_data;
  logic        testpat_sel;
  logic        s_ready, b_ready, s_hold, b_hold;
  logic        s_start, b_start, s_rw, b_rw;
  logic [AW-1:0] s_addr, b_addr;
  logic [15:0] s_data, b_data;
  logic        s_busy, b_busy, s_done, b_done, s_ovf, b_ovf;
  logic [2:0]  s_lat, b_lat;

  int total = 0;
  int bad   = 0;
  int s_starts = 0;
  int b_starts = 0;
  logic [35:0] s_exp[$];
  logic [35:0] b_exp[$];

  always #5 clk = ~clk;

  pixel_capture #(.ADDR_W(AW), .FRAME_WORDS(4), .FIFO_DEPTH(8)) u_small (
    .clk(clk), .reset_n(reset_n), .capture_req(req_s),
    .pixel_clk(pixel_clk), .pixel_vsync(pixel_vsync), .pixel_hsync(pixel_hsync),
    .pixel_data(pixel_data),
`ifdef PIXEL_CAPTURE_TESTPAT_EN
    .testpat_sel(testpat_sel),
`endif
    .sram_ready(s_ready), .pixel_start(s_start), .pixel_rw(s_rw),
    .pixel_sram_addr(s_addr), .pixel_sram_data(s_data),
    .busy(s_busy), .done(s_done), .overflow(s_ovf)
  );

  pixel_capture #(.ADDR_W(AW), .FRAME_WORDS(12), .FIFO_DEPTH(8)) u_big (
    .clk(clk), .reset_n(reset_n), .capture_req(req_b),
    .pixel_clk(pixel_clk), .pixel_vsync(pixel_vsync), .pixel_hsync(pixel_hsync),
    .pixel_data(pixel_data),
`ifdef PIXEL_CAPTURE_TESTPAT_EN
    .testpat_sel(1'b0),
`endif
    .sram_ready(b_ready), .pixel_start(b_start), .pixel_rw(b_rw),
    .pixel_sram_addr(b_addr), .pixel_sram_data(b_data),
    .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  // SRAM controllers: busy for three cycles after each start, optionally held not-ready.
  always @(posedge clk) begin
    if (!reset_n) begin
      s_lat <= '0;
      b_lat <= '0;
    end else begin
      if (s_start == 1'b0) s_lat <= 3'd3;
      else if (s_lat != 0) s_lat <= s_lat - 3'd1;
      if (b_start == 1'b0) b_lat <= 3'd3;
      else if (b_lat != 0) b_lat <= b_lat - 3'd1;
    end
  end
  assign s_ready = !s_hold && (s_lat == 0);
  assign b_ready = !b_hold && (b_lat == 0);

  // Write monitors: every start pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (s_start === 1'b0) begin
      s_starts++;
      total++;
      assert (s_exp.size() != 0) else begin
        bad++;
        $error("FAIL s_unexpected_write observed=%0h@%0h expected=none", s_data, s_addr);
      end
      if (s_exp.size() != 0) begin
        logic [35:0] want;
        want = s_exp.pop_front();
        total++;
        assert ({s_addr, s_data} === want && s_rw === 1'b0) else begin
          bad++;
          $error("FAIL s_write observed=%0h@%0h rw=%b expected=%0h@%0h rw=0",
                 s_data, s_addr, s_rw, want[15:0], want[35:16]);
        end
      end
    end
    if (b_start === 1'b0) begin
      b_starts++;
      total++;
      assert (b_exp.size() != 0) else begin
        bad++;
        $error("FAIL b_unexpected_write observed=%0h@%0h expected=none", b_data, b_addr);
      end
      if (b_exp.size() != 0) begin
        logic [35:0] want;
        want = b_exp.pop_front();
        total++;
        assert ({b_addr, b_data} === want && b_rw === 1'b0) else begin
          bad++;
          $error("FAIL b_write observed=%0h@%0h rw=%b expected=%0h@%0h rw=0",
                 b_data, b_addr, b_rw, want[15:0], want[35:16]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    pixel_data = b;
    pixel_clk  = 1'b0;
    tick(4);
    pixel_clk  = 1'b1;
    tick(4);
  endtask

  task automatic pulse_s();
    req_s = 1'b1; tick(1); req_s = 1'b0;
  endtask

  task automatic pulse_b();
    req_b = 1'b1; tick(1); req_b = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic which_big);
    int n = 0;
    while (((which_big ? b_done : s_done) !== 1'b1) && n < 2000) begin
      tick(1);
      n++;
    end
    chk(tag, {35'd0, (which_big ? b_done : s_done)}, 36'd1);
  endtask

  task automatic wait_b_starts(input string tag, input int target);
    int n = 0;
    while (b_starts < target && n < 2000) begin
      tick(1);
      n++;
    end
    chk(tag, 36'(b_starts), 36'(target));
  endtask

  initial begin
    int base;
    reset_n = 1'b0; req_s = 1'b0; req_b = 1'b0;
    pixel_clk = 1'b0; pixel_vsync = 1'b1; pixel_hsync = 1'b0; pixel_data = '0;
    testpat_sel = 1'b0; s_hold = 1'b0; b_hold = 1'b0;
    tick(3);
    chk("rst_start", {35'd0, s_start}, 36'd1);
    chk("rst_rw", {35'd0, s_rw}, 36'd0);
    chk("rst_addr", 36'(s_addr), 36'd0);
    chk("rst_data", 36'(s_data), 36'd0);
    chk("rst_flags", {33'd0, s_busy, s_done, s_ovf}, 36'd0);
    chk("rst_flags_b", {32'd0, b_start, b_busy, b_done, b_ovf}, 36'h8);
    reset_n = 1'b1;
    tick(4);

    // Frame limit: ten bytes, only four words fit.
    base = s_starts;
    for (int n = 0; n < 4; n++) s_exp.push_back({20'(n), 8'(2*n+1), 8'(2*n+2)});
    pulse_s();
    chk("arm_busy", {34'd0, s_busy, s_done}, 36'h2);
    pixel_vsync = 1'b0; tick(6);
    pixel_hsync = 1'b1;
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    pixel_hsync = 1'b0;
    wait_done("limit_done", 1'b0);
    chk("limit_busy", {35'd0, s_busy}, 36'd0);
    chk("limit_starts", 36'(s_starts - base), 36'd4);
    chk("limit_queue", 36'(s_exp.size()), 36'd0);
    pixel_vsync = 1'b1; tick(6);

    // Odd byte flushed by vsync; capture_req while busy is ignored.
    base = s_starts;
    s_exp.push_back({20'd0, 16'hAABB});
    s_exp.push_back({20'd1, 16'hCC00});
    pulse_s();
    chk("rearm_flags", {33'd0, s_busy, s_done, s_ovf}, 36'h4);
    pulse_s();
    chk("rearm_ignored", {34'd0, s_busy, s_done}, 36'h2);
    pixel_vsync = 1'b0; tick(6);
    pixel_hsync = 1'b1;
    send_byte(8'hAA);
    pulse_s();
    send_byte(8'hBB);
    send_byte(8'hCC);
    pixel_hsync = 1'b0; tick(2);
    pixel_vsync = 1'b1;
    wait_done("odd_done", 1'b0);
    chk("odd_starts", 36'(s_starts - base), 36'd2);
    chk("odd_queue", 36'(s_exp.size()), 36'd0);

    // Overflow: SRAM held busy while ten words arrive; words 8 and 9 are dropped.
    base = b_starts;
    b_hold = 1'b1;
    for (int n = 0; n < 8; n++) b_exp.push_back({20'(n), 8'(2*n+1), 8'(2*n+2)});
    b_exp.push_back({20'd10, 16'h1516});
    b_exp.push_back({20'd11, 16'h1718});
    pulse_b();
    pixel_vsync = 1'b0; tick(6);
    pixel_hsync = 1'b1;
    for (int i = 1; i <= 20; i++) send_byte(8'(i));
    chk("ovf_set", {35'd0, b_ovf}, 36'd1);
    chk("ovf_no_writes", 36'(b_starts - base), 36'd0);
    chk("ovf_busy", {35'd0, b_busy}, 36'd1);
    b_hold = 1'b0;
    wait_b_starts("ovf_drain", base + 8);
    tick(10);
    for (int i = 21; i <= 24; i++) send_byte(8'(i));
    pixel_hsync = 1'b0;
    wait_done("ovf_done", 1'b1);
    chk("ovf_starts", 36'(b_starts - base), 36'd10);
    chk("ovf_queue", 36'(b_exp.size()), 36'd0);
    chk("ovf_sticky", {35'd0, b_ovf}, 36'd1);
    pixel_vsync = 1'b1; tick(6);
    pulse_b();
    chk("ovf_cleared", {33'd0, b_busy, b_done, b_ovf}, 36'h4);

    // Reset while a write is in flight.
    base = b_starts;
    b_hold = 1'b1;
    b_exp.push_back({20'd0, 16'h3132});
    pixel_vsync = 1'b0; tick(6);
    pixel_hsync = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h31 + i));
    pixel_hsync = 1'b0;
    b_hold = 1'b0;
    wait_b_starts("inflight_first", base + 1);
    reset_n = 1'b0;
    tick(1);
    chk("mid_rst_start", {35'd0, b_start}, 36'd1);
    chk("mid_rst_busy", {35'd0, b_busy}, 36'd0);
    chk("mid_rst_fifo", {35'd0, u_big.u_fifo.empty}, 36'd1);
    chk("mid_rst_addr", 36'(b_addr), 36'd0);
    reset_n = 1'b1;
    pixel_hsync = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i));
    pixel_hsync = 1'b0;
    tick(60);
    chk("post_rst_starts", 36'(b_starts - base), 36'd1);
    chk("post_rst_queue", 36'(b_exp.size()), 36'd0);

`ifdef PIXEL_CAPTURE_TESTPAT_EN
    // Test pattern: data follows the address, camera bytes discarded.
    base = s_starts;
    testpat_sel = 1'b1;
    pixel_vsync = 1'b1; tick(6);
    for (int n = 0; n < 3; n++) s_exp.push_back({20'(n), 16'(n)});
    pulse_s();
    pixel_vsync = 1'b0; tick(6);
    pixel_hsync = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i));
    pixel_hsync = 1'b0; tick(2);
    pixel_vsync = 1'b1;
    wait_done("tp_done", 1'b0);
    chk("tp_starts", 36'(s_starts - base), 36'd3);
    chk("tp_queue", 36'(s_exp.size()), 36'd0);
    testpat_sel = 1'b0;
`endif

    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_capture.md
Name: pixel_capture

Overview:
- Camera-side write master for the single-buffer frame store.
- Samples the OV-style camera bus (pixel_clk, vsync, hsync/href, 8-bit data) in the system clock domain.
- Packs byte pairs into 16-bit words and buffers them in a small FIFO.
- Issues SRAM write transactions on the mux "A" group (start/rw/addr/data, ready), capturing exactly one frame per arm request.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- FRAME_WORDS, 307200, words per frame (640x480 RGB565); capture stops once this count is written.
- FIFO_DEPTH, 8, word FIFO depth (power of 2).

Ports:
- clk  in  1  system clock (sys_clk); must be at least 4x pixel_clk
- reset_n  in  1  synchronous active-low reset
- capture_req  in  1  one-cycle pulse; arms capture of the next frame
- pixel_clk  in  1  camera pixel clock (asynchronous)
- pixel_vsync  in  1  camera vsync, high during vertical blank
- pixel_hsync  in  1  camera href, high while line data is valid
- pixel_data  in  8  camera data byte
- sram_ready  in  1  SRAM controller idle/complete
- pixel_start  out  1  active-low one-cycle transaction start (to start_a)
- pixel_rw  out  1  0 = write, 1 = read; held 0
- pixel_sram_addr  out  ADDR_W  word address
- pixel_sram_data  out  16  write data
- busy  out  1  armed or capturing or draining
- done  out  1  frame completely written; held until next capture_req
- overflow  out  1  sticky: at least one word dropped; cleared by capture_req

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pixel_start=1, pixel_rw=0, pixel_sram_addr=0, pixel_sram_data=0, busy=0, done=0, overflow=0.
  - FIFO emptied, packer cleared, both FSMs return to idle.
  - Applies mid-frame and mid-transaction; the SRAM controller shares the reset.
- Input sync:
  - pixel_clk, vsync, hsync and data each pass through 2 flops.
  - A data byte is taken on the synchronized pixel_clk rising edge when synced hsync=1.
- Capture FSM:
  - IDLE: on capture_req, go to ARM; set busy=1, done=0, overflow=0.
  - ARM: wait for the synced vsync falling edge (frame start), then go to CAPTURE; packer cleared, word counter=0.
  - CAPTURE:
    - First byte of a pair -> data[15:8]; second -> data[7:0].
    - A complete word is pushed as {addr, data}; the word counter increments after each push.
    - When the counter reaches FRAME_WORDS, further bytes are ignored -> DRAIN.
    - A synced vsync rising edge first -> DRAIN. A pending odd byte is pushed with low byte 0x00.
  - DRAIN: wait until the FIFO is empty and the write FSM is idle -> DONE.
  - DONE: busy=0, done=1. capture_req -> ARM.
  - capture_req in ARM, CAPTURE or DRAIN is ignored.
- Overflow: a push into a full FIFO drops that word and sets overflow=1. The word counter/address still increments, so later words land at the correct address.
- Write FSM (W_IDLE, W_ISSUE, W_WAIT_BUSY, W_WAIT_DONE):
  - W_IDLE: FIFO non-empty and sram_ready=1 -> pop, register addr/data -> W_ISSUE.
  - W_ISSUE: pixel_start=0 for exactly 1 cycle -> W_WAIT_BUSY.
  - W_WAIT_BUSY: wait for sram_ready=0 -> W_WAIT_DONE.
  - W_WAIT_DONE: wait for sram_ready=1 -> W_IDLE.
  - addr/data stay stable from W_ISSUE until the return to W_IDLE.
  - Latency: pop to pixel_start low is 1 cycle; one transaction at a time.
- Simultaneous push and pop on the same cycle are both honoured; a full FIFO with a simultaneous pop accepts the push.
- Address: word n -> address n. No wrap, since FRAME_WORDS <= 2^ADDR_W.

Optional Feature:
- Macro: PIXEL_CAPTURE_TESTPAT_EN.
- Defined: adds input testpat_sel (1 bit). When testpat_sel=1, each pushed word's data = address[15:0]. Camera timing still drives pushes and the camera byte values are discarded.
- Undefined: no port, no logic; data always comes from the camera.

Decomposition:
- Package pixel_capture_pkg:
  - capture and write FSM state enums.
  - RW_WRITE=1'b0 and RW_READ=1'b1.
  - DEFAULT_FRAME_WORDS.
- Sub-module sync_fifo (parameterized width/depth, full/empty, push/pop) instantiated with width ADDR_W+16.

Test Plan:
- Reset mid-CAPTURE with a transaction in flight: pixel_start=1, busy=0, FIFO empty next cycle, and no further starts occur.
- FRAME_WORDS=4, capture_req, then a 10-byte line 0x01..0x0A: writes addr0=0x0102, 1=0x0304, 2=0x0506, 3=0x0708. Bytes 0x09/0x0A ignored, done=1, exactly 4 start pulses.
- 3 bytes 0xAA,0xBB,0xCC, then vsync rises: writes 0xAABB@0 and 0xCC00@1, done=1.
- Hold sram_ready=0 while streaming more than 2*FIFO_DEPTH bytes: overflow=1. After release, surviving words are at their correct addresses and there are no gaps beyond the dropped ones.
- capture_req while busy: ignored, counter unaffected. capture_req after done: done=0, overflow=0, then re-arms on the next vsync fall.
- PIXEL_CAPTURE_TESTPAT_EN with testpat_sel=1 and FRAME_WORDS=3: data written = 0x0000, 0x0001, 0x0002.
